// File: rtl/gestor_solicitudes_if.sv
// Call interface between the request front end (master) and the cabin controller (slave).
interface gestor_solicitudes_if;
  logic       req_valid;
  logic [1:0] req_piso;
  logic       req_ack;
  logic [1:0] piso_actual;
  logic       puertas;

  modport master (output req_valid, req_piso, input req_ack, piso_actual, puertas);
  modport slave  (input req_valid, req_piso, output req_ack, piso_actual, puertas);
endinterface

// File: rtl/gestor_solicitudes.sv
// Elevator request front end: debounces buttons, latches calls, offers targets over the call interface.
// Optional DIR_AWARE_CLEAR_EN: service clears only the hall call matching the scan direction.
module gestor_solicitudes #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       piso1_i,
  input  logic       piso2_i,
  input  logic       piso3_i,
  input  logic       piso4_i,
  input  logic       S1_i,
  input  logic       S2_i,
  input  logic       S3_i,
  input  logic       B2_i,
  input  logic       B3_i,
  input  logic       B4_i,
  gestor_solicitudes_if.master bus,
  output logic [3:0] memoria_m_o,
  output logic [2:0] sube_pend_o,
  output logic [2:0] baja_pend_o,
  output logic       dir_o
);
  localparam int NB = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OFFER, WAIT} state_t;

  // Button lanes: [3:0] cabin 1..4, [6:4] up 1..3, [9:7] down 2..4
  logic [NB-1:0]            raw, lvl_q, lvl_d, rise;
  logic [NB-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] mem_q, mem_d, clr_m, pend;
  logic [2:0] sub_q, sub_d, clr_s;
  logic [2:0] baj_q, baj_d, clr_b;
  logic [1:0] cur;

  state_t     state_q, state_d;
  logic       vld_q, vld_d;
  logic [1:0] piso_q, piso_d;
  logic       dir_q, dir_d;
  logic       up_hit, dn_hit;
  logic [1:0] up_t, dn_t;

  assign raw = {B4_i, B3_i, B2_i, S3_i, S2_i, S1_i, piso4_i, piso3_i, piso2_i, piso1_i};
  assign cur = bus.piso_actual;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (raw[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = ~lvl_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign rise = lvl_d & ~lvl_q;

  // Hall bits of the served floor; up exists for floors 1..3, down for 2..4
  always_comb begin
    clr_m = '0;
    clr_s = '0;
    clr_b = '0;
    if (bus.puertas) begin
      clr_m[cur] = 1'b1;
`ifdef DIR_AWARE_CLEAR_EN
      if (cur != 2'd3 && (dir_q || cur == 2'd0)) clr_s[cur] = 1'b1;
      if (cur != 2'd0 && (!dir_q || cur == 2'd3)) clr_b[cur - 2'd1] = 1'b1;
`else
      if (cur != 2'd3) clr_s[cur] = 1'b1;
      if (cur != 2'd0) clr_b[cur - 2'd1] = 1'b1;
`endif
    end
  end

  // Clear dominates a same-cycle set
  assign mem_d = (mem_q | rise[3:0]) & ~clr_m;
  assign sub_d = (sub_q | rise[6:4]) & ~clr_s;
  assign baj_d = (baj_q | rise[9:7]) & ~clr_b;

  assign pend = mem_q | {1'b0, sub_q} | {baj_q, 1'b0};

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    piso_d  = piso_q;
    dir_d   = dir_q;
    up_hit  = 1'b0;
    up_t    = 2'd0;
    dn_hit  = 1'b0;
    dn_t    = 2'd0;
    // Descending scan leaves the lowest floor above; ascending leaves the highest below
    for (int f = 3; f >= 0; f--) begin
      if (f > int'(cur) && pend[f[1:0]]) begin
        up_hit = 1'b1;
        up_t   = f[1:0];
      end
    end
    for (int f = 0; f < 4; f++) begin
      if (f < int'(cur) && pend[f[1:0]]) begin
        dn_hit = 1'b1;
        dn_t   = f[1:0];
      end
    end
    case (state_q)
      IDLE: begin
        if (|pend) begin
          state_d = OFFER;
          vld_d   = 1'b1;
          if (pend[cur])              piso_d = cur;
          else if (dir_q && up_hit)   piso_d = up_t;
          else if (!dir_q && dn_hit)  piso_d = dn_t;
          else begin
            dir_d  = ~dir_q;
            piso_d = dir_q ? dn_t : up_t;
          end
        end
      end
      OFFER: begin
        if (bus.req_ack) begin
          vld_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.puertas && cur == piso_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q   <= '0;
      cnt_q   <= '0;
      mem_q   <= '0;
      sub_q   <= '0;
      baj_q   <= '0;
      state_q <= IDLE;
      vld_q   <= 1'b0;
      piso_q  <= 2'd0;
      dir_q   <= 1'b1;
    end else begin
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      sub_q   <= sub_d;
      baj_q   <= baj_d;
      state_q <= state_d;
      vld_q   <= vld_d;
      piso_q  <= piso_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.req_valid = vld_q;
  assign bus.req_piso  = piso_q;
  assign memoria_m_o   = mem_q;
  assign sube_pend_o   = sub_q;
  assign baja_pend_o   = baj_q;
  assign dir_o         = dir_q;
endmodule

// File: tb/tb_gestor_solicitudes.sv
// Directed bench for gestor_solicitudes: reset, debounce, handshake, scan order, clearing, mid-WAIT reset.
module tb_gestor_solicitudes;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic p1, p2, p3, p4, s1, s2, s3, b2, b3, b4;
  logic [3:0] mem;
  logic [2:0] sub, baj;
  logic dir;
  int checks = 0;
  int errors = 0;

  gestor_solicitudes_if bus ();

  gestor_solicitudes #(.DEB_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .piso1_i(p1), .piso2_i(p2), .piso3_i(p3), .piso4_i(p4),
    .S1_i(s1), .S2_i(s2), .S3_i(s3), .B2_i(b2), .B3_i(b3), .B4_i(b4),
    .bus(bus.master),
    .memoria_m_o(mem), .sube_pend_o(sub), .baja_pend_o(baj), .dir_o(dir)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs;
    {p1, p2, p3, p4, s1, s2, s3, b2, b3, b4} = '0;
    bus.req_ack = 1'b0;
    bus.piso_actual = 2'd0;
    bus.puertas = 1'b0;
  endtask

  task automatic do_reset;
    clr_inputs();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    int seen;
    clr_inputs();
    rst = 1'b1;
    tick(2);
    checks++; if (mem !== 4'b0 || sub !== 3'b0 || baj !== 3'b0) begin errors++;
      $display("FAIL reset_pend: got m=%b s=%b b=%b exp 0", mem, sub, baj); end
    checks++; if (bus.req_valid !== 1'b0 || bus.req_piso !== 2'd0) begin errors++;
      $display("FAIL reset_req: got v=%b p=%0d exp 0/0", bus.req_valid, bus.req_piso); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b exp 1", dir); end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      bus.req_ack = (i >= 25);
      tick(1);
      if (bus.req_valid !== 1'b0) seen++;
    end
    bus.req_ack = 1'b0;
    checks++; if (seen != 0) begin errors++;
      $display("FAIL idle_no_offer: got %0d valid cycles exp 0", seen); end
  endtask

  task automatic test_debounce;
    do_reset();
    p3 = 1'b1;
    tick(3);
    p3 = 1'b0;
    tick(5);
    checks++; if (mem !== 4'b0000) begin errors++;
      $display("FAIL glitch: got m=%b exp 0000", mem); end
    p3 = 1'b1;
    tick(3);
    checks++; if (mem !== 4'b0000) begin errors++;
      $display("FAIL deb_early: got m=%b exp 0000", mem); end
    tick(1);
    checks++; if (mem !== 4'b0100 || bus.req_valid !== 1'b0) begin errors++;
      $display("FAIL deb_accept: got m=%b v=%b exp 0100/0", mem, bus.req_valid); end
    tick(1);
    checks++; if (bus.req_valid !== 1'b1 || bus.req_piso !== 2'd2) begin errors++;
      $display("FAIL first_offer: got v=%b p=%0d exp 1/2", bus.req_valid, bus.req_piso); end
    p3 = 1'b0;
  endtask

  task automatic test_handshake;
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.req_valid !== 1'b1 || bus.req_piso !== 2'd2) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL offer_hold: got %0d unstable cycles exp 0", bad); end
    bus.req_ack = 1'b1;
    tick(1);
    bus.req_ack = 1'b0;
    checks++; if (bus.req_valid !== 1'b0) begin errors++;
      $display("FAIL ack_drop: got v=%b exp 0", bus.req_valid); end
    bus.req_ack = 1'b1;
    tick(1);
    bus.req_ack = 1'b0;
    tick(1);
    checks++; if (bus.req_valid !== 1'b0) begin errors++;
      $display("FAIL wait_ack_ignored: got v=%b exp 0", bus.req_valid); end
    bus.piso_actual = 2'd2;
    bus.puertas = 1'b1;
    tick(1);
    checks++; if (mem !== 4'b0000) begin errors++;
      $display("FAIL serve_clear: got m=%b exp 0000", mem); end
    bus.puertas = 1'b0;
    tick(3);
    checks++; if (bus.req_valid !== 1'b0) begin errors++;
      $display("FAIL idle_after_serve: got v=%b exp 0", bus.req_valid); end
  endtask

  task automatic test_scan;
    do_reset();
    bus.piso_actual = 2'd1;
    p1 = 1'b1; p4 = 1'b1;
    tick(4);
    checks++; if (mem !== 4'b1001) begin errors++;
      $display("FAIL scan_latch: got m=%b exp 1001", mem); end
    p1 = 1'b0; p4 = 1'b0;
    tick(1);
    checks++; if (bus.req_valid !== 1'b1 || bus.req_piso !== 2'd3 || dir !== 1'b1) begin errors++;
      $display("FAIL scan_up: got v=%b p=%0d d=%b exp 1/3/1", bus.req_valid, bus.req_piso, dir); end
    bus.req_ack = 1'b1;
    tick(1);
    bus.req_ack = 1'b0;
    bus.piso_actual = 2'd3;
    bus.puertas = 1'b1;
    tick(1);
    checks++; if (mem !== 4'b0001 || dir !== 1'b1) begin errors++;
      $display("FAIL scan_serve3: got m=%b d=%b exp 0001/1", mem, dir); end
    bus.puertas = 1'b0;
    tick(1);
    checks++; if (bus.req_valid !== 1'b1 || bus.req_piso !== 2'd0 || dir !== 1'b0) begin errors++;
      $display("FAIL scan_reverse: got v=%b p=%0d d=%b exp 1/0/0", bus.req_valid, bus.req_piso, dir); end
    bus.req_ack = 1'b1;
    tick(1);
    bus.req_ack = 1'b0;
    bus.piso_actual = 2'd0;
    bus.puertas = 1'b1;
    tick(1);
    bus.puertas = 1'b0;
    checks++; if (mem !== 4'b0000) begin errors++;
      $display("FAIL scan_serve0: got m=%b exp 0000", mem); end
  endtask

  task automatic test_clear_priority;
    logic [2:0] exp_b;
`ifdef DIR_AWARE_CLEAR_EN
    exp_b = 3'b001;
`else
    exp_b = 3'b000;
`endif
    do_reset();
    bus.piso_actual = 2'd1;
    bus.puertas = 1'b1;
    s2 = 1'b1; b2 = 1'b1;
    tick(6);
    checks++; if (sub !== 3'b000) begin errors++;
      $display("FAIL prio_up: got s=%b exp 000", sub); end
    checks++; if (baj !== exp_b) begin errors++;
      $display("FAIL prio_down: got b=%b exp %b", baj, exp_b); end
    s2 = 1'b0; b2 = 1'b0;
    tick(5);
    bus.puertas = 1'b0;
  endtask

  task automatic test_served_clear;
    do_reset();
    s2 = 1'b1; b2 = 1'b1;
    tick(4);
    checks++; if (sub !== 3'b010 || baj !== 3'b001) begin errors++;
      $display("FAIL hall_latch: got s=%b b=%b exp 010/001", sub, baj); end
    s2 = 1'b0; b2 = 1'b0;
    tick(1);
    checks++; if (bus.req_valid !== 1'b1 || bus.req_piso !== 2'd1) begin errors++;
      $display("FAIL hall_offer: got v=%b p=%0d exp 1/1", bus.req_valid, bus.req_piso); end
    bus.req_ack = 1'b1;
    tick(1);
    bus.req_ack = 1'b0;
    bus.piso_actual = 2'd1;
    bus.puertas = 1'b1;
    tick(1);
    checks++; if (sub !== 3'b000) begin errors++;
      $display("FAIL serve_up: got s=%b exp 000", sub); end
`ifdef DIR_AWARE_CLEAR_EN
    checks++; if (baj !== 3'b001) begin errors++;
      $display("FAIL serve_down_kept: got b=%b exp 001", baj); end
    bus.puertas = 1'b0;
    bus.piso_actual = 2'd3;
    tick(1);
    checks++; if (bus.req_valid !== 1'b1 || bus.req_piso !== 2'd1 || dir !== 1'b0) begin errors++;
      $display("FAIL down_offer: got v=%b p=%0d d=%b exp 1/1/0", bus.req_valid, bus.req_piso, dir); end
    bus.req_ack = 1'b1;
    tick(1);
    bus.req_ack = 1'b0;
    bus.piso_actual = 2'd1;
    bus.puertas = 1'b1;
    tick(1);
    checks++; if (baj !== 3'b000) begin errors++;
      $display("FAIL serve_down: got b=%b exp 000", baj); end
    bus.puertas = 1'b0;
`else
    checks++; if (baj !== 3'b000) begin errors++;
      $display("FAIL serve_down: got b=%b exp 000", baj); end
    bus.puertas = 1'b0;
    bus.piso_actual = 2'd3;
    tick(1);
    checks++; if (bus.req_valid !== 1'b0) begin errors++;
      $display("FAIL no_reoffer: got v=%b exp 0", bus.req_valid); end
`endif
  endtask

  task automatic test_stale_target;
    do_reset();
    p2 = 1'b1;
    tick(4);
    p2 = 1'b0;
    tick(1);
    bus.piso_actual = 2'd1;
    bus.puertas = 1'b1;
    tick(1);
    bus.puertas = 1'b0;
    tick(1);
    checks++; if (mem !== 4'b0000 || bus.req_valid !== 1'b1 || bus.req_piso !== 2'd1) begin errors++;
      $display("FAIL stale_hold: got m=%b v=%b p=%0d exp 0000/1/1", mem, bus.req_valid, bus.req_piso); end
    bus.req_ack = 1'b1;
    tick(1);
    bus.req_ack = 1'b0;
    bus.puertas = 1'b1;
    tick(1);
    bus.puertas = 1'b0;
    tick(2);
    checks++; if (bus.req_valid !== 1'b0) begin errors++;
      $display("FAIL stale_done: got v=%b exp 0", bus.req_valid); end
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    p2 = 1'b1; p4 = 1'b1;
    tick(4);
    checks++; if (mem !== 4'b1010) begin errors++;
      $display("FAIL mw_latch: got m=%b exp 1010", mem); end
    p2 = 1'b0; p4 = 1'b0;
    tick(1);
    checks++; if (bus.req_valid !== 1'b1 || bus.req_piso !== 2'd1) begin errors++;
      $display("FAIL mw_offer: got v=%b p=%0d exp 1/1", bus.req_valid, bus.req_piso); end
    bus.req_ack = 1'b1;
    tick(1);
    bus.req_ack = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (mem !== 4'b0 || sub !== 3'b0 || baj !== 3'b0 || bus.req_valid !== 1'b0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL mw_reset: got m=%b s=%b b=%b v=%b d=%b exp 0/0/0/0/1", mem, sub, baj, bus.req_valid, dir);
    end
    tick(5);
    checks++; if (bus.req_valid !== 1'b0) begin errors++;
      $display("FAIL mw_idle: got v=%b exp 0", bus.req_valid); end
    p3 = 1'b1;
    tick(4);
    p3 = 1'b0;
    tick(1);
    checks++; if (bus.req_valid !== 1'b1 || bus.req_piso !== 2'd2) begin errors++;
      $display("FAIL mw_new_offer: got v=%b p=%0d exp 1/2", bus.req_valid, bus.req_piso); end
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_debounce();
    test_handshake();
    test_scan();
    test_clear_priority();
    test_served_clear();
    test_stale_target();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
